// File: rtl/hf_tans_recoder_p_pkg.sv
// Shared encodings, width helpers and the reference L=8 tables for the
// Huffman-to-tANS recoder.
package hf_tans_pkg;

  typedef enum logic [2:0] {
    SEL_LS     = 3'd0,
    SEL_START  = 3'd1,
    SEL_ENC    = 3'd2,
    SEL_HCOUNT = 3'd3,
    SEL_HFIRST = 3'd4,
    SEL_HINDEX = 3'd5,
    SEL_HSYM   = 3'd6
  } cfg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  function automatic int unsigned state_w(input int unsigned r);
    return r + 1;
  endfunction

  function automatic int unsigned len_w(input int unsigned r);
    return $clog2(r + 2);
  endfunction

  localparam int unsigned DEF_LS    [4] = '{5, 0, 2, 1};
  localparam int unsigned DEF_START [4] = '{0, 0, 5, 7};
  localparam int unsigned DEF_ENC   [8] = '{8, 9, 10, 11, 12, 13, 14, 15};

endpackage

// File: rtl/hf_tans_recoder_p_if.sv
// Configuration, bit-input, beat-output and status bundle of the recoder.
interface hf_tans_recoder_p_if
  import hf_tans_pkg::*;
#(
  parameter int unsigned R  = 3,
  parameter int unsigned CW = 16
);
  logic                    cfg_we;
  logic [2:0]              cfg_sel;
  logic [7:0]              cfg_addr;
  logic [CW-1:0]           cfg_data;
  logic                    in_valid;
  logic                    in_bit;
  logic                    in_last;
  logic                    in_ready;
  logic                    out_valid;
  logic [state_w(R)-1:0]   out_bits;
  logic [len_w(R)-1:0]     out_len;
  logic                    out_ready;
  logic                    done;
  logic                    err;
  logic [state_w(R)-1:0]   final_state;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_data, in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_bits, out_len, done, err, final_state
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_data, in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_bits, out_len, done, err, final_state
  );
endinterface

// File: rtl/hf_tans_recoder_p_prefix_decoder.sv
// Canonical-Huffman prefix decoder: programmable tables, code/len accumulators
// and a one-entry symbol holding register with valid/ready.
module hf_prefix_decoder
  import hf_tans_pkg::*;
#(
  parameter int unsigned NSYM   = 4,
  parameter int unsigned MAXLEN = 4,
  parameter int unsigned CW     = 16,
  localparam int unsigned SW    = (NSYM > 1) ? $clog2(NSYM) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_we_i,
  input  logic [2:0]    cfg_sel_i,
  input  logic [7:0]    cfg_addr_i,
  input  logic [CW-1:0] cfg_data_i,
  input  logic          bit_fire_i,
  input  logic          bit_i,
  input  logic          last_i,
  input  logic          start_i,
  output logic          hold_free_o,
  output logic          sym_valid_o,
  output logic [SW-1:0] sym_o,
  input  logic          sym_ready_i,
  output logic          err_o
);
  localparam int unsigned IW = MAXLEN + 1;
  localparam int unsigned CL = $clog2(MAXLEN + 1);

  logic [IW-1:0]     cnt_q   [MAXLEN+1];
  logic [IW-1:0]     first_q [MAXLEN+1];
  logic [IW-1:0]     index_q [MAXLEN+1];
  logic [SW-1:0]     sym_q   [NSYM];

  logic [MAXLEN-1:0] code_q, code_d, code_base, code_n;
  logic [CL-1:0]     len_q, len_d, len_base, len_n;
  logic              hold_v_q, hold_v_d;
  logic [SW-1:0]     hold_sym_q, hold_sym_d;
  logic [IW-1:0]     diff, sidx;
  logic              match, err_c;
  logic [SW-1:0]     sym_c;

  always_comb begin
    code_base = start_i ? '0 : code_q;
    len_base  = start_i ? '0 : len_q;
    code_n    = {code_base[MAXLEN-2:0], bit_i};
    len_n     = len_base + CL'(1);
    // Wrap below hf_first lands far above any legal count, so one compare suffices.
    diff      = {1'b0, code_n} - first_q[len_n];
    match     = diff < cnt_q[len_n];
    sidx      = index_q[len_n] + diff;
    sym_c     = '0;
    for (int unsigned i = 0; i < NSYM; i++) begin
      if (sidx == IW'(i)) sym_c = sym_q[i];
    end
    err_c = bit_fire_i && !match && ((len_n == CL'(MAXLEN)) || last_i);

    code_d     = code_q;
    len_d      = len_q;
    hold_v_d   = hold_v_q;
    hold_sym_d = hold_sym_q;
    if (bit_fire_i) begin
      if (match || err_c) begin
        code_d = '0;
        len_d  = '0;
      end else begin
        code_d = code_n;
        len_d  = len_n;
      end
    end
    if (hold_v_q && sym_ready_i) hold_v_d = 1'b0;
    if (bit_fire_i && match) begin
      hold_v_d   = 1'b1;
      hold_sym_d = sym_c;
    end
  end

  assign hold_free_o = !hold_v_q || sym_ready_i;
  assign sym_valid_o = hold_v_q;
  assign sym_o       = hold_sym_q;
  assign err_o       = err_c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i <= MAXLEN; i++) begin
        cnt_q[i]   <= '0;
        first_q[i] <= '0;
        index_q[i] <= '0;
      end
      for (int unsigned i = 0; i < NSYM; i++) sym_q[i] <= '0;
      code_q     <= '0;
      len_q      <= '0;
      hold_v_q   <= 1'b0;
      hold_sym_q <= '0;
    end else begin
      if (cfg_we_i) begin
        for (int unsigned i = 0; i <= MAXLEN; i++) begin
          if (cfg_addr_i == 8'(i)) begin
            case (cfg_sel_e'(cfg_sel_i))
              SEL_HCOUNT: cnt_q[i]   <= IW'(cfg_data_i);
              SEL_HFIRST: first_q[i] <= IW'(cfg_data_i);
              SEL_HINDEX: index_q[i] <= IW'(cfg_data_i);
              default: ;
            endcase
          end
        end
        for (int unsigned i = 0; i < NSYM; i++) begin
          if (cfg_addr_i == 8'(i) && cfg_sel_e'(cfg_sel_i) == SEL_HSYM) sym_q[i] <= SW'(cfg_data_i);
        end
      end
      code_q     <= code_d;
      len_q      <= len_d;
      hold_v_q   <= hold_v_d;
      hold_sym_q <= hold_sym_d;
    end
  end

endmodule

// File: rtl/hf_tans_recoder_p.sv
// Huffman-to-tANS recoder: bit-serial prefix decode feeding a one-symbol-per-cycle
// tANS encoder with a stallable output register and stream framing.
module hf_tans_recoder_p
  import hf_tans_pkg::*;
#(
  parameter int unsigned R      = 3,
  parameter int unsigned NSYM   = 4,
  parameter int unsigned MAXLEN = 4,
  parameter int unsigned CW     = 16
) (
  input logic                PHI,
  input logic                RST,
  hf_tans_recoder_p_if.slave bus
);
  localparam int unsigned XW  = state_w(R);
  localparam int unsigned LW  = len_w(R);
  localparam int unsigned L   = 1 << R;
  localparam int unsigned IXW = R + 2;
  localparam int unsigned SW  = (NSYM > 1) ? $clog2(NSYM) : 1;

  state_e          state_q, state_d;
  logic [XW-1:0]   ls_q    [NSYM];
  logic [XW-1:0]   start_q [NSYM];
  logic [XW-1:0]   enc_q   [L];
  logic [XW-1:0]   x_q, x_d, fin_q, fin_d, ob_q, ob_d;
  logic [LW-1:0]   ol_q, ol_d;
  logic            ov_q, ov_d, err_q, err_d, done_q, done_d;

  logic            idle_like, in_rdy, bit_fire, start, cfg_ok;
  logic            hold_free, sym_v, sym_ready, dec_err, enc_fire;
  logic [SW-1:0]   sym;
  logic [XW-1:0]   ls_c, ones, mask, bits_c, shifted, xn;
  logic [IXW-1:0]  lim, idx;
  logic [LW-1:0]   nb;
  logic            found, oob, ls_zero;

  assign idle_like = state_q inside {ST_IDLE, ST_DONE};
  assign in_rdy    = !RST && (state_q != ST_FLUSH) && hold_free;
  assign bit_fire  = bus.in_valid && in_rdy;
  assign start     = bit_fire && idle_like;
  assign cfg_ok    = bus.cfg_we && idle_like && !start;
  assign sym_ready = !ov_q || bus.out_ready;
  assign enc_fire  = sym_v && sym_ready;

  hf_prefix_decoder #(.NSYM(NSYM), .MAXLEN(MAXLEN), .CW(CW)) u_dec (
    .clk_i       (PHI),
    .rst_i       (RST),
    .cfg_we_i    (cfg_ok),
    .cfg_sel_i   (bus.cfg_sel),
    .cfg_addr_i  (bus.cfg_addr),
    .cfg_data_i  (bus.cfg_data),
    .bit_fire_i  (bit_fire),
    .bit_i       (bus.in_bit),
    .last_i      (bus.in_last),
    .start_i     (start),
    .hold_free_o (hold_free),
    .sym_valid_o (sym_v),
    .sym_o       (sym),
    .sym_ready_i (sym_ready),
    .err_o       (dec_err)
  );

  always_comb begin
    ls_c  = ls_q[sym];
    lim   = {ls_c, 1'b0} - IXW'(1);
    nb    = LW'(R + 1);
    found = 1'b0;
    for (int unsigned k = 0; k <= R + 1; k++) begin
      if (!found && (IXW'(x_q >> k) <= lim)) begin
        nb    = LW'(k);
        found = 1'b1;
      end
    end
    ones    = '1;
    mask    = ~(ones << nb);
    bits_c  = x_q & mask;
    shifted = x_q >> nb;
    idx     = IXW'(start_q[sym]) + IXW'(shifted) - IXW'(ls_c);
    oob     = idx >= IXW'(L);
    xn      = oob ? '0 : enc_q[idx[R-1:0]];
    ls_zero = (ls_c == '0);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    err_d   = err_q;
    done_d  = 1'b0;
    fin_d   = fin_q;
    ov_d    = ov_q;
    ob_d    = ob_q;
    ol_d    = ol_q;
    if (start) begin
      x_d   = XW'(L);
      err_d = 1'b0;
    end
    if (ov_q && bus.out_ready) ov_d = 1'b0;
    if (enc_fire) begin
      if (ls_zero) begin
        err_d = 1'b1;
      end else begin
        ov_d = 1'b1;
        ob_d = bits_c;
        ol_d = nb;
        x_d  = xn;
        if (oob) err_d = 1'b1;
      end
    end
    if (dec_err) err_d = 1'b1;
    case (state_q)
      ST_IDLE, ST_DONE: if (bit_fire) state_d = (bus.in_last || dec_err) ? ST_FLUSH : ST_RUN;
      ST_RUN:           if (bit_fire && (bus.in_last || dec_err)) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (!sym_v && !ov_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          fin_d   = x_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PHI or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      x_q     <= XW'(L);
      fin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      ob_q    <= '0;
      ol_q    <= '0;
      for (int unsigned i = 0; i < NSYM; i++) begin
        ls_q[i]    <= '0;
        start_q[i] <= '0;
      end
      for (int unsigned i = 0; i < L; i++) enc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      ob_q    <= ob_d;
      ol_q    <= ol_d;
      if (cfg_ok) begin
        for (int unsigned i = 0; i < NSYM; i++) begin
          if (bus.cfg_addr == 8'(i) && cfg_sel_e'(bus.cfg_sel) == SEL_LS)    ls_q[i]    <= XW'(bus.cfg_data);
          if (bus.cfg_addr == 8'(i) && cfg_sel_e'(bus.cfg_sel) == SEL_START) start_q[i] <= XW'(bus.cfg_data);
        end
        for (int unsigned i = 0; i < L; i++) begin
          if (bus.cfg_addr == 8'(i) && cfg_sel_e'(bus.cfg_sel) == SEL_ENC) enc_q[i] <= XW'(bus.cfg_data);
        end
      end
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = ov_q;
  assign bus.out_bits    = ob_q;
  assign bus.out_len     = ol_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.final_state = fin_q;

endmodule

// File: tb/tb_hf_tans_recoder_p.sv
// Scoreboard bench for hf_tans_recoder_p: directed streams push expected beats and
// end-of-stream reports; a negedge monitor pops and compares.
module tb_hf_tans_recoder_p;
  import hf_tans_pkg::*;

  localparam int unsigned R = 3, NSYM = 4, MAXLEN = 4, CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hf_tans_recoder_p_if #(.R(R), .CW(CW)) bus ();

  hf_tans_recoder_p #(.R(R), .NSYM(NSYM), .MAXLEN(MAXLEN), .CW(CW)) dut (
    .PHI (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct packed { logic [2:0] len; logic [3:0] bits; } beat_t;
  typedef struct packed { logic [3:0] fs;  logic err; }        fin_t;

  beat_t exp_beats[$];
  fin_t  exp_fins[$];
  beat_t mon_b;
  fin_t  mon_f;
  int unsigned n_checks = 0, n_errors = 0, done_seen = 0;
  int unsigned st_budget;

  task automatic check(input string name, input int unsigned got, input int unsigned want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic void exp_beat(input int unsigned len, input int unsigned bits);
    exp_beats.push_back('{len: 3'(len), bits: 4'(bits)});
  endfunction

  function automatic void exp_fin(input int unsigned fs, input int unsigned e);
    exp_fins.push_back('{fs: 4'(fs), err: 1'(e)});
  endfunction

  function automatic void exp_basic();
    exp_beat(0, 0);
    exp_beat(2, 3);
    exp_beat(3, 5);
    exp_fin(15, 0);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_beats.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got len=%0d bits=%0d, expected no beat", bus.out_len, bus.out_bits);
        end else begin
          mon_b = exp_beats.pop_front();
          check("beat_len", 32'(bus.out_len), 32'(mon_b.len));
          check("beat_bits", 32'(bus.out_bits), 32'(mon_b.bits));
        end
      end
      if (bus.done) begin
        done_seen++;
        if (exp_fins.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done with final_state=%0d, expected no done", bus.final_state);
        end else begin
          mon_f = exp_fins.pop_front();
          check("final_state", 32'(bus.final_state), 32'(mon_f.fs));
          check("err_at_done", 32'(bus.err), 32'(mon_f.err));
        end
      end
    end
  end

  task automatic cfg_write(input logic [2:0] sel, input int unsigned addr, input int unsigned data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_addr = 8'(addr);
    bus.cfg_data = CW'(data);
    @(posedge clk); #1;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic program_defaults();
    for (int unsigned i = 0; i < 4; i++) cfg_write(SEL_LS, i, DEF_LS[i]);
    for (int unsigned i = 0; i < 4; i++) cfg_write(SEL_START, i, DEF_START[i]);
    for (int unsigned i = 0; i < 8; i++) cfg_write(SEL_ENC, i, DEF_ENC[i]);
    cfg_write(SEL_HCOUNT, 1, 1);
    cfg_write(SEL_HFIRST, 1, 0);
    cfg_write(SEL_HINDEX, 1, 0);
    cfg_write(SEL_HCOUNT, 2, 2);
    cfg_write(SEL_HFIRST, 2, 2);
    cfg_write(SEL_HINDEX, 2, 1);
    cfg_write(SEL_HSYM, 0, 0);
    cfg_write(SEL_HSYM, 1, 2);
    cfg_write(SEL_HSYM, 2, 3);
  endtask

  // bits[0] is the first bit sent; with_cfg holds an enc_tab[3]=0 write alongside every bit.
  task automatic send(input logic [7:0] bits, input int unsigned n, input bit last, input bit with_cfg);
    for (int unsigned i = 0; i < n; i++) begin
      bit acc;
      int unsigned budget;
      bus.in_valid = 1'b1;
      bus.in_bit   = bits[i];
      bus.in_last  = last && (i == n - 1);
      if (with_cfg) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = SEL_ENC;
        bus.cfg_addr = 8'd3;
        bus.cfg_data = '0;
      end
      acc    = 1'b0;
      budget = 0;
      while (!acc && budget < 100) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: bit %0d got no in_ready, expected acceptance within 100 cycles", i);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target, input string name);
    int unsigned budget = 0;
    while (done_seen < target && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    check({name, "_done_count"}, done_seen, target);
    check({name, "_beats_left"}, exp_beats.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we    = 1'b0;
    bus.cfg_sel   = '0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    #3;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_final", 32'(bus.final_state), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;
    program_defaults();

    // A,B,C: 0 / 10 / 11
    exp_basic();
    send(8'b11010, 5, 1'b1, 1'b0);
    wait_done(1, "basic");

    // Same stream with the first beat held for five cycles.
    bus.out_ready = 1'b0;
    exp_basic();
    fork
      send(8'b11010, 5, 1'b1, 1'b0);
      begin
        st_budget = 0;
        @(negedge clk);
        while (!bus.out_valid && st_budget < 50) begin
          @(negedge clk);
          st_budget++;
        end
        check("stall_first_valid", 32'(bus.out_valid), 1);
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", 32'(bus.out_valid), 1);
          check("stall_len", 32'(bus.out_len), 0);
          check("stall_bits", 32'(bus.out_bits), 0);
        end
        check("stall_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_done(2, "stall");

    exp_fin(8, 1);
    send(8'b1, 1, 1'b1, 1'b0);
    wait_done(3, "incomplete_code");

    cfg_write(SEL_LS, 0, 0);
    exp_fin(8, 1);
    send(8'b0, 1, 1'b1, 1'b0);
    wait_done(4, "ls_zero");
    cfg_write(SEL_LS, 0, 5);

    // C,C: full-width beats
    exp_beat(3, 0);
    exp_beat(3, 7);
    exp_fin(15, 0);
    send(8'b1111, 4, 1'b1, 1'b0);
    wait_done(5, "cc");

    // Abort mid-stream, then replay after reprogramming.
    bus.out_ready = 1'b0;
    send(8'b010, 3, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check("abort_in_ready", 32'(bus.in_ready), 0);
    check("abort_out_valid", 32'(bus.out_valid), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_err", 32'(bus.err), 0);
    check("abort_final", 32'(bus.final_state), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    program_defaults();
    exp_basic();
    send(8'b11010, 5, 1'b1, 1'b0);
    wait_done(6, "replay");

    // start[0]=5 drives the A index to 8, past the table.
    cfg_write(SEL_START, 0, 5);
    exp_beat(0, 0);
    exp_fin(0, 1);
    send(8'b0, 1, 1'b1, 1'b0);
    wait_done(7, "index_oob");
    cfg_write(SEL_START, 0, 0);

    exp_basic();
    send(8'b11010, 5, 1'b1, 1'b1);
    wait_done(8, "cfg_in_run");
    exp_basic();
    send(8'b11010, 5, 1'b1, 1'b0);
    wait_done(9, "back_to_back");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
